// File: rtl/overlay_draw_engine.sv
// Overlay draw engine: rasterises clear-band, glyph and rectangle-outline commands into
// one-pixel-per-cycle writes on a 2^L_W x 2^L_W overlay RAM.
module overlay_draw_engine #(
  parameter int unsigned A_W    = 8,
  parameter int unsigned L_W    = 8,
  parameter int unsigned C_W    = 3,
  parameter int unsigned FONT_H = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [A_W-1:0]   i_ascii,
  input  logic [C_W-1:0]   i_color,
  input  logic [L_W-1:0]   i_ys,
  input  logic [L_W-1:0]   i_ye,
  input  logic [L_W-1:0]   i_x,
  input  logic [L_W-1:0]   i_y,
  input  logic [L_W-1:0]   i_x1,
  input  logic [L_W-1:0]   i_y1,
  input  logic [L_W-1:0]   i_x2,
  input  logic [L_W-1:0]   i_y2,
  output logic [A_W+3:0]   o_font_addr,
  input  logic [7:0]       i_font_data,
  output logic             o_wr_en,
  output logic [2*L_W-1:0] o_wr_addr,
  output logic [C_W-1:0]   o_wr_data,
  output logic             o_busy
);

  typedef enum logic [3:0] {
    StIdle, StClr, StChrFetch, StChrWait, StChrPix, StRTop, StRBot, StRLeft, StRRight
  } state_e;

  localparam logic [L_W:0] MaxCoord = {1'b0, {L_W{1'b1}}};
  localparam logic [L_W:0] One      = {{L_W{1'b0}}, 1'b1};
  localparam logic [3:0]   LastRow  = 4'(FONT_H - 1);

  state_e         state_q;
  // Counters carry one extra bit so the 255 end-of-line compare never wraps
  logic [L_W:0]   x_q, y_q, xa_q, ya_q, xb_q, yb_q;
  logic [A_W-1:0] ascii_q;
  logic [3:0]     row_q;
  logic [2:0]     col_q;
  logic [7:0]     glyph_q;

  logic           accept;
  logic [L_W-1:0] xmin, xmax, ymin, ymax;
  logic [L_W:0]   x_inc, y_inc;
  logic [2:0]     col_n;
  logic [7:0]     bits_n;
  logic [L_W:0]   chr_px, chr_py;
  logic           chr_on;
  logic [3:0]     row_inc;

  assign accept  = i_cmd_valid & o_cmd_ready;
  assign o_busy  = ~o_cmd_ready;
  assign xmin    = (i_x1 > i_x2) ? i_x2 : i_x1;
  assign xmax    = (i_x1 > i_x2) ? i_x1 : i_x2;
  assign ymin    = (i_y1 > i_y2) ? i_y2 : i_y1;
  assign ymax    = (i_y1 > i_y2) ? i_y1 : i_y2;
  assign x_inc   = x_q + One;
  assign y_inc   = y_q + One;
  assign row_inc = row_q + 4'd1;

  // Next glyph pixel: column 0 straight from the ROM in CHR_WAIT, later ones from the latch
  assign col_n  = (state_q == StChrPix) ? col_q + 3'd1 : 3'd0;
  assign bits_n = (state_q == StChrPix) ? glyph_q : i_font_data;
  assign chr_px = xa_q + {{(L_W-2){1'b0}}, col_n};
  assign chr_py = ya_q + {{(L_W-3){1'b0}}, row_q};
  assign chr_on = bits_n[3'd7 - col_n] && (chr_px <= MaxCoord) && (chr_py <= MaxCoord);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      o_cmd_ready <= 1'b1;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_font_addr <= '0;
      x_q         <= '0;
      y_q         <= '0;
      xa_q        <= '0;
      ya_q        <= '0;
      xb_q        <= '0;
      yb_q        <= '0;
      ascii_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      glyph_q     <= '0;
    end else begin
      o_wr_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (i_cmd_op)
              2'b00: begin
                if (i_ys <= i_ye) begin
                  state_q     <= StClr;
                  o_cmd_ready <= 1'b0;
                  x_q         <= '0;
                  y_q         <= {1'b0, i_ys};
                  yb_q        <= {1'b0, i_ye};
                  o_wr_en     <= 1'b1;
                  o_wr_addr   <= {i_ys, {L_W{1'b0}}};
                  o_wr_data   <= '0;
                end
              end
              2'b01: begin
                // Space and NUL render nothing, so they are swallowed here
                if (i_ascii != A_W'(8'h00) && i_ascii != A_W'(8'h20)) begin
                  state_q     <= StChrFetch;
                  o_cmd_ready <= 1'b0;
                  ascii_q     <= i_ascii;
                  xa_q        <= {1'b0, i_x};
                  ya_q        <= {1'b0, i_y};
                  row_q       <= '0;
                  o_font_addr <= {i_ascii, 4'd0};
                  o_wr_data   <= i_color;
                end
              end
              2'b10: begin
                if (|{i_x1, i_y1, i_x2, i_y2}) begin
                  state_q     <= StRTop;
                  o_cmd_ready <= 1'b0;
                  xa_q        <= {1'b0, xmin};
                  xb_q        <= {1'b0, xmax};
                  ya_q        <= {1'b0, ymin};
                  yb_q        <= {1'b0, ymax};
                  x_q         <= {1'b0, xmin};
                  y_q         <= {1'b0, ymin};
                  o_wr_en     <= 1'b1;
                  o_wr_addr   <= {ymin, xmin};
                  o_wr_data   <= i_color;
                end
              end
              default: ;
            endcase
          end
        end
        StClr: begin
          if (x_q == MaxCoord) begin
            if (y_q == yb_q) begin
              state_q     <= StIdle;
              o_cmd_ready <= 1'b1;
            end else begin
              x_q       <= '0;
              y_q       <= y_inc;
              o_wr_en   <= 1'b1;
              o_wr_addr <= {y_inc[L_W-1:0], {L_W{1'b0}}};
            end
          end else begin
            x_q       <= x_inc;
            o_wr_en   <= 1'b1;
            o_wr_addr <= {y_q[L_W-1:0], x_inc[L_W-1:0]};
          end
        end
        StChrFetch: state_q <= StChrWait;
        StChrWait: begin
          state_q   <= StChrPix;
          glyph_q   <= i_font_data;
          col_q     <= '0;
          o_wr_en   <= chr_on;
          o_wr_addr <= {chr_py[L_W-1:0], chr_px[L_W-1:0]};
        end
        StChrPix: begin
          if (col_q == 3'd7) begin
            if (row_q == LastRow) begin
              state_q     <= StIdle;
              o_cmd_ready <= 1'b1;
            end else begin
              state_q     <= StChrFetch;
              row_q       <= row_inc;
              o_font_addr <= {ascii_q, row_inc};
            end
          end else begin
            col_q     <= col_n;
            o_wr_en   <= chr_on;
            o_wr_addr <= {chr_py[L_W-1:0], chr_px[L_W-1:0]};
          end
        end
        StRTop: begin
          o_wr_en <= 1'b1;
          if (x_q == xb_q) begin
            state_q   <= StRBot;
            x_q       <= xa_q;
            y_q       <= yb_q;
            o_wr_addr <= {yb_q[L_W-1:0], xa_q[L_W-1:0]};
          end else begin
            x_q       <= x_inc;
            o_wr_addr <= {y_q[L_W-1:0], x_inc[L_W-1:0]};
          end
        end
        StRBot: begin
          o_wr_en <= 1'b1;
          if (x_q == xb_q) begin
            state_q   <= StRLeft;
            x_q       <= xa_q;
            y_q       <= ya_q;
            o_wr_addr <= {ya_q[L_W-1:0], xa_q[L_W-1:0]};
          end else begin
            x_q       <= x_inc;
            o_wr_addr <= {y_q[L_W-1:0], x_inc[L_W-1:0]};
          end
        end
        StRLeft: begin
          o_wr_en <= 1'b1;
          if (y_q == yb_q) begin
            state_q   <= StRRight;
            x_q       <= xb_q;
            y_q       <= ya_q;
            o_wr_addr <= {ya_q[L_W-1:0], xb_q[L_W-1:0]};
          end else begin
            y_q       <= y_inc;
            o_wr_addr <= {y_inc[L_W-1:0], x_q[L_W-1:0]};
          end
        end
        StRRight: begin
          if (y_q == yb_q) begin
            state_q     <= StIdle;
            o_cmd_ready <= 1'b1;
          end else begin
            y_q       <= y_inc;
            o_wr_en   <= 1'b1;
            o_wr_addr <= {y_inc[L_W-1:0], x_q[L_W-1:0]};
          end
        end
        default: begin
          state_q     <= StIdle;
          o_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_overlay_draw_engine.sv
// Bench for overlay_draw_engine: directed and random commands, expected pixel writes from a
// list-based reference model, checked by a scoreboard monitor on the write port.
module tb_overlay_draw_engine;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op;
  logic [7:0]  i_ascii;
  logic [2:0]  i_color;
  logic [7:0]  i_ys, i_ye, i_x, i_y, i_x1, i_y1, i_x2, i_y2;
  logic [11:0] o_font_addr;
  logic [7:0]  i_font_data = 8'h00;
  logic        o_wr_en;
  logic [15:0] o_wr_addr;
  logic [2:0]  o_wr_data;
  logic        o_busy;

  overlay_draw_engine #(.A_W(8), .L_W(8), .C_W(3), .FONT_H(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_ascii     (i_ascii),
    .i_color     (i_color),
    .i_ys        (i_ys),
    .i_ye        (i_ye),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_x1        (i_x1),
    .i_y1        (i_y1),
    .i_x2        (i_x2),
    .i_y2        (i_y2),
    .o_font_addr (o_font_addr),
    .i_font_data (i_font_data),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] addr;
    logic [2:0]  data;
  } wr_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] ascii;
    logic [2:0] color;
    logic [7:0] ys, ye, x, y, x1, y1, x2, y2;
  } cmd_t;

  logic [7:0]  font [4096];
  wr_t         sb[$];
  wr_t         exp_w;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  // Font ROM with one cycle of read latency
  always @(posedge sys_clk) i_font_data <= font[o_font_addr];
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (sys_rst === 1'b0) begin
      n_cmp++;
      if (o_busy !== ~o_cmd_ready) begin
        n_err++;
        $display("FAIL busy_vs_ready: got busy=%b ready=%b, required busy=~ready", o_busy, o_cmd_ready);
      end
    end
    if (o_wr_en === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: got cyc=%0d addr=%h data=%0d, required no write",
                 cyc, o_wr_addr, o_wr_data);
      end else begin
        exp_w = sb.pop_front();
        if (exp_w.cyc != cyc || exp_w.addr !== o_wr_addr || exp_w.data !== o_wr_data) begin
          n_err++;
          $display("FAIL write_check: got cyc=%0d addr=%h data=%0d, required cyc=%0d addr=%h data=%0d",
                   cyc, o_wr_addr, o_wr_data, exp_w.cyc, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  function automatic void put(input int unsigned cy, input int yy, input int xx,
                              input logic [2:0] d);
    wr_t w;
    logic [7:0] ya, xa;
    ya = yy[7:0];
    xa = xx[7:0];
    w.cyc  = cy;
    w.addr = {ya, xa};
    w.data = d;
    sb.push_back(w);
  endfunction

  // Reference model: enqueue every expected write with its cycle; return cycles until ready
  function automatic int unsigned model(input cmd_t c, input int unsigned acc);
    int unsigned k;
    int xmin, xmax, ymin, ymax;
    logic [3:0]  r4;
    logic [11:0] fa;
    logic [7:0]  bits;
    k = 0;
    case (c.op)
      2'b00: begin
        if (c.ys > c.ye) return 1;
        for (int yy = int'(c.ys); yy <= int'(c.ye); yy++)
          for (int xx = 0; xx < 256; xx++) begin
            put(acc + 1 + k, yy, xx, 3'd0);
            k++;
          end
        return k + 1;
      end
      2'b01: begin
        if (c.ascii == 8'h00 || c.ascii == 8'h20) return 1;
        for (int r = 0; r < 16; r++) begin
          r4   = r[3:0];
          fa   = {c.ascii, r4};
          bits = font[fa];
          for (int cc = 0; cc < 8; cc++)
            if (bits[7-cc] && int'(c.x) + cc <= 255 && int'(c.y) + r <= 255)
              put(acc + 3 + 10*r + cc, int'(c.y) + r, int'(c.x) + cc, c.color);
        end
        return 161;
      end
      2'b10: begin
        if (c.x1 == 0 && c.y1 == 0 && c.x2 == 0 && c.y2 == 0) return 1;
        xmin = (c.x1 < c.x2) ? int'(c.x1) : int'(c.x2);
        xmax = (c.x1 < c.x2) ? int'(c.x2) : int'(c.x1);
        ymin = (c.y1 < c.y2) ? int'(c.y1) : int'(c.y2);
        ymax = (c.y1 < c.y2) ? int'(c.y2) : int'(c.y1);
        for (int xx = xmin; xx <= xmax; xx++) begin put(acc + 1 + k, ymin, xx, c.color); k++; end
        for (int xx = xmin; xx <= xmax; xx++) begin put(acc + 1 + k, ymax, xx, c.color); k++; end
        for (int yy = ymin; yy <= ymax; yy++) begin put(acc + 1 + k, yy, xmin, c.color); k++; end
        for (int yy = ymin; yy <= ymax; yy++) begin put(acc + 1 + k, yy, xmax, c.color); k++; end
        return k + 1;
      end
      default: return 1;
    endcase
  endfunction

  function automatic cmd_t mk(input logic [1:0] op, input logic [7:0] ascii,
                              input logic [2:0] color, input logic [7:0] ys, ye, x, y,
                              input logic [7:0] x1, y1, x2, y2);
    cmd_t c;
    c.op = op; c.ascii = ascii; c.color = color; c.ys = ys; c.ye = ye; c.x = x; c.y = y;
    c.x1 = x1; c.y1 = y1; c.x2 = x2; c.y2 = y2;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op    = 2'($urandom_range(0, 3));
    c.ascii = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'($urandom);
    c.color = 3'($urandom);
    c.ys    = 8'($urandom);
    c.ye    = c.ys + 8'($urandom_range(0, 2));
    if ($urandom_range(0, 5) == 0) begin
      c.ys = 8'($urandom_range(1, 255));
      c.ye = 8'($urandom_range(0, int'(c.ys) - 1));
    end
    c.x  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(245, 255));
    c.y  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(240, 255));
    c.x1 = 8'($urandom); c.y1 = 8'($urandom); c.x2 = 8'($urandom); c.y2 = 8'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      c.x1 = 8'd0; c.y1 = 8'd0; c.x2 = 8'd0; c.y2 = 8'd0;
    end
    return c;
  endfunction

  task automatic apply(input cmd_t c);
    i_cmd_op = c.op; i_ascii = c.ascii; i_color = c.color; i_ys = c.ys; i_ye = c.ye;
    i_x = c.x; i_y = c.y; i_x1 = c.x1; i_y1 = c.y1; i_x2 = c.x2; i_y2 = c.y2;
  endtask

  task automatic chk(input string what, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", what, got, req);
    end
  endtask

  // Bounded wait for ready; then check when it came and that all expected writes were seen
  task automatic check_ready(input string what, input int unsigned exp_cyc);
    int unsigned n;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 70000) begin
      @(negedge sys_clk);
      n++;
    end
    n_cmp++;
    if (o_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_timeout: got busy after %0d cycles, required ready at cycle %0d",
               what, n, exp_cyc);
    end else if (cyc != exp_cyc) begin
      n_err++;
      $display("FAIL %s ready_cycle: got %0d, required %0d", what, cyc, exp_cyc);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s drained: got %0d writes outstanding, required 0", what, sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input cmd_t c, input string what);
    int unsigned acc, lat, n;
    apply(c);
    i_cmd_valid = 1'b1;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 70000) begin
      @(negedge sys_clk);
      n++;
    end
    acc = cyc;
    lat = model(c, acc);
    @(negedge sys_clk);
    i_cmd_valid = 1'b0;
    check_ready(what, acc + lat);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_t        c;
    int unsigned acc, lat, n;
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom);
    font[12'h410] = 8'hFF;

    sys_rst = 1'b1;
    i_cmd_valid = 1'b0;
    apply(mk(2'b00, 8'h00, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("reset_ready", 32'(o_cmd_ready), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_wr_en", 32'(o_wr_en), 32'd0);
    chk("reset_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("reset_wr_data", 32'(o_wr_data), 32'd0);
    chk("reset_font_addr", 32'(o_font_addr), 32'd0);

    send(mk(2'b00, 8'h00, 3'd5, 8'd128, 8'd191, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), "clear_band");
    send(mk(2'b01, 8'h41, 3'b010, 8'd0, 8'd0, 8'd250, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0), "char_clip");
    send(mk(2'b10, 8'h00, 3'b100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd40, 8'd60, 8'd10, 8'd20), "rect_swap");
    send(mk(2'b10, 8'h00, 3'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), "rect_zero");
    send(mk(2'b10, 8'h00, 3'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd5), "rect_point");
    send(mk(2'b01, 8'h20, 3'd1, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0), "char_space");
    send(mk(2'b01, 8'h00, 3'd1, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0), "char_nul");
    send(mk(2'b11, 8'h41, 3'd1, 8'd0, 8'd9, 8'd3, 8'd4, 8'd1, 8'd1, 8'd2, 8'd2), "op_reserved");
    send(mk(2'b00, 8'h00, 3'd0, 8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), "clear_inv");
    send(mk(2'b00, 8'h00, 3'd6, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), "clear_last");
    send(mk(2'b01, 8'h5A, 3'd6, 8'd0, 8'd0, 8'd0, 8'd247, 8'd0, 8'd0, 8'd0, 8'd0), "char_yclip");
    send(mk(2'b10, 8'h00, 3'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255), "rect_full");

    // Valid held high with scrambled fields while a clear is running
    c = mk(2'b00, 8'h00, 3'd0, 8'd10, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    apply(c);
    i_cmd_valid = 1'b1;
    acc = cyc;
    lat = model(c, acc);
    @(negedge sys_clk);
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 70000) begin
      apply(rand_cmd());
      @(negedge sys_clk);
      n++;
    end
    check_ready("hold_first", acc + lat);
    c = mk(2'b10, 8'h00, 3'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd7, 8'd9, 8'd2);
    apply(c);
    acc = cyc;
    lat = model(c, acc);
    @(negedge sys_clk);
    i_cmd_valid = 1'b0;
    check_ready("hold_next", acc + lat);

    // Reset 30 cycles into a rectangle
    c = mk(2'b10, 8'h00, 3'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50);
    apply(c);
    i_cmd_valid = 1'b1;
    acc = cyc;
    lat = model(c, acc);
    @(negedge sys_clk);
    i_cmd_valid = 1'b0;
    while (cyc < acc + 30) @(negedge sys_clk);
    sys_rst = 1'b1;
    while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_ready", 32'(o_cmd_ready), 32'd1);
    chk("midrst_wr_en", 32'(o_wr_en), 32'd0);
    chk("midrst_drained", sb.size(), 32'd0);
    sb.delete();
    send(mk(2'b01, 8'h41, 3'd3, 8'd0, 8'd0, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0), "post_rst_char");

    for (int i = 0; i < 30; i++) send(rand_cmd(), "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
